// File: rtl/flag_scanner.sv
// flag_scanner: captures a flag vector on start and scans it STEP bits per clock for the first set bit.
// FLAG_SCAN_ABORT_EN adds an abort input that cancels a running scan without a done pulse.
module flag_scanner #(
  parameter int WIDTH = 16,
  parameter int STEP = 1,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] flags,
  input  logic             dir,
`ifdef FLAG_SCAN_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [IDX_W-1:0] index
);
  localparam int NCHUNK = WIDTH / STEP;
  localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] shadow, shadow_n;
  logic dir_q, dir_n;
  logic [CW-1:0] c, c_n;
  logic found_n;
  logic [IDX_W-1:0] index_n, hit_idx, p;
  logic hit, kill;
`ifdef FLAG_SCAN_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif
  assign busy = state != IDLE;
  assign done = state == DONE;
  // walk the current chunk in scan order so the first set bit met wins
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    p = '0;
    for (int i = 0; i < STEP; i++) begin
      p = dir_q ? IDX_W'(WIDTH - 1 - int'(c) * STEP - i) : IDX_W'(int'(c) * STEP + i);
      if (!hit && shadow[p]) begin
        hit = 1'b1;
        hit_idx = p;
      end
    end
  end
  always_comb begin
    state_n = state;
    shadow_n = shadow;
    dir_n = dir_q;
    c_n = c;
    found_n = found;
    index_n = index;
    if (state == IDLE && start) begin
      state_n = SCAN;
      shadow_n = flags;
      dir_n = dir;
      c_n = '0;
      found_n = 1'b0;
      index_n = '0;
    end else if (state == SCAN) begin
      if (kill) state_n = IDLE;
      else if (hit) begin
        state_n = DONE;
        found_n = 1'b1;
        index_n = hit_idx;
      end else if (c == CW'(NCHUNK - 1)) state_n = DONE;
      else c_n = c + CW'(1);
    end else if (state == DONE) state_n = IDLE;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      shadow <= '0;
      dir_q <= 1'b0;
      c <= '0;
      found <= 1'b0;
      index <= '0;
    end else begin
      state <= state_n;
      shadow <= shadow_n;
      dir_q <= dir_n;
      c <= c_n;
      found <= found_n;
      index <= index_n;
    end
  end
endmodule

// File: tb/tb_flag_scanner.sv
// tb_flag_scanner: table-driven check of flag_scanner with STEP=1 and STEP=4 instances sharing stimulus.
module tb_flag_scanner;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] flags = '0;
  logic dir = 1'b0;
  logic busy1, done1, found1, busy4, done4, found4;
  logic [3:0] index1, index4;
  int checks = 0;
  int failures = 0;
`ifdef FLAG_SCAN_ABORT_EN
  logic abort = 1'b0;
`endif
  always #5 clock = ~clock;

  flag_scanner #(.WIDTH(16), .STEP(1)) u1 (
    .clock(clock), .reset_n(reset_n), .start(start), .flags(flags), .dir(dir),
`ifdef FLAG_SCAN_ABORT_EN
    .abort(abort),
`endif
    .busy(busy1), .done(done1), .found(found1), .index(index1));

  flag_scanner #(.WIDTH(16), .STEP(4)) u4 (
    .clock(clock), .reset_n(reset_n), .start(start), .flags(flags), .dir(dir),
`ifdef FLAG_SCAN_ABORT_EN
    .abort(abort),
`endif
    .busy(busy4), .done(done4), .found(found4), .index(index4));

  typedef struct {
    string nm;
    logic [15:0] f;
    logic d;
    int f1, i1, l1;
    int f4, i4, l4;
  } vec_t;

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endfunction

  task automatic run(input vec_t v, input bit disturb);
    int l1 = 0, l4 = 0, io1 = 0, io4 = 0;
    logic fo1 = 1'b0, fo4 = 1'b0;
    @(negedge clock);
    flags = v.f;
    dir = v.d;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk({v.nm, " busy1"}, 32'(busy1), 1);
    chk({v.nm, " busy4"}, 32'(busy4), 1);
    for (int k = 1; k <= 40 && (l1 == 0 || l4 == 0); k++) begin
      @(posedge clock);
      #1;
      if (done1 && l1 == 0) begin l1 = k; fo1 = found1; io1 = 32'(index1); end
      if (done4 && l4 == 0) begin l4 = k; fo4 = found4; io4 = 32'(index4); end
      if (disturb && k == 4) begin start = 1'b1; flags = 16'h0001; dir = 1'b1; end
      if (disturb && k == 5) start = 1'b0;
    end
    chk({v.nm, " lat1"}, 32'(l1), 32'(v.l1));
    chk({v.nm, " found1"}, 32'(fo1), 32'(v.f1));
    chk({v.nm, " index1"}, 32'(io1), 32'(v.i1));
    chk({v.nm, " lat4"}, 32'(l4), 32'(v.l4));
    chk({v.nm, " found4"}, 32'(fo4), 32'(v.f4));
    chk({v.nm, " index4"}, 32'(io4), 32'(v.i4));
    @(posedge clock);
    #1;
    chk({v.nm, " done_low"}, {30'd0, done1, done4}, 0);
    chk({v.nm, " idle"}, {30'd0, busy1, busy4}, 0);
    chk({v.nm, " hold1"}, {27'd0, found1, index1}, 32'(v.f1 * 16 + v.i1));
    chk({v.nm, " hold4"}, {27'd0, found4, index4}, 32'(v.f4 * 16 + v.i4));
  endtask

  vec_t tbl[12];
  int ndone;

  initial begin
    tbl[0]  = '{"h2000_d0", 16'h2000, 1'b0, 1, 13, 14, 1, 13, 4};
    tbl[1]  = '{"h2000_d1", 16'h2000, 1'b1, 1, 13, 3, 1, 13, 1};
    tbl[2]  = '{"h0000_d0", 16'h0000, 1'b0, 0, 0, 16, 0, 0, 4};
    tbl[3]  = '{"h0000_d1", 16'h0000, 1'b1, 0, 0, 16, 0, 0, 4};
    tbl[4]  = '{"h0101_d0", 16'h0101, 1'b0, 1, 0, 1, 1, 0, 1};
    tbl[5]  = '{"h0101_d1", 16'h0101, 1'b1, 1, 8, 8, 1, 8, 2};
    tbl[6]  = '{"h8001_d0", 16'h8001, 1'b0, 1, 0, 1, 1, 0, 1};
    tbl[7]  = '{"h8001_d1", 16'h8001, 1'b1, 1, 15, 1, 1, 15, 1};
    tbl[8]  = '{"h00f0_d0", 16'h00f0, 1'b0, 1, 4, 5, 1, 4, 2};
    tbl[9]  = '{"h00f0_d1", 16'h00f0, 1'b1, 1, 7, 9, 1, 7, 3};
    tbl[10] = '{"h8000_d0", 16'h8000, 1'b0, 1, 15, 16, 1, 15, 4};
    tbl[11] = '{"h0001_d1", 16'h0001, 1'b1, 1, 0, 16, 1, 0, 4};
    repeat (2) @(negedge clock);
    chk("reset_out1", {26'd0, busy1, done1, found1, index1}, 0);
    chk("reset_out4", {26'd0, busy4, done4, found4, index4}, 0);
    reset_n = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 12; i++) run(tbl[i], 1'b0);
    // restart and flag changes while busy, including during the STEP=4 done cycle
    run('{"disturb", 16'h2000, 1'b0, 1, 13, 14, 1, 13, 4}, 1'b1);
    // reset mid-scan
    @(negedge clock);
    flags = 16'h0000;
    dir = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_out1", {26'd0, busy1, done1, found1, index1}, 0);
    chk("midrst_out4", {26'd0, busy4, done4, found4, index4}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(posedge clock);
      #1;
      ndone += int'(done1) + int'(done4) + int'(busy1) + int'(busy4);
    end
    chk("midrst_quiet", 32'(ndone), 0);
    run(tbl[1], 1'b0);
`ifdef FLAG_SCAN_ABORT_EN
    @(negedge clock);
    flags = 16'h2000;
    dir = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    chk("abort_busy", {30'd0, busy1, busy4}, 0);
    chk("abort_done", {30'd0, done1, done4}, 0);
    chk("abort_found", {30'd0, found1, found4}, 0);
    ndone = 0;
    repeat (16) begin
      @(posedge clock);
      #1;
      ndone += int'(done1) + int'(done4);
    end
    chk("abort_nodone", 32'(ndone), 0);
    run(tbl[0], 1'b0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
